alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: plays a small stored program into the CPU, one
// command strobe per instruction, with idle gap cycles after ALU operations.
module alu_cmd_sequencer #(
    parameter int unsigned OP_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [17:0] prog_data,
    input  logic [3:0]  prog_last,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  data_in,
    output logic [7:0]  opcode,
    output logic        cin,
    output logic        load,
    output logic        ce,
    output logic        busy,
    output logic        done
);

    localparam int unsigned GapW = (OP_GAP < 2) ? 1 : $clog2(OP_GAP + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StGap,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      pc_q, pc_d;
    logic [3:0]      last_q, last_d;
    logic [GapW-1:0] gap_q, gap_d;
    // Instruction word as presented to the CPU: {load, cin, opcode, data}
    logic [17:0]     cmd_q, cmd_d;
    logic            ce_q, ce_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [17:0]     mem_q [16];

    // Program memory: no reset so contents survive rst and abort
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Next-state logic; abort overrides every transition out of a running state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        gap_d   = gap_q;
        cmd_d   = cmd_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = 4'd0;
                    last_d  = prog_last;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                cmd_d   = mem_q[pc_q];
                state_d = StIssue;
            end
            StIssue: begin
                if (cmd_q[17] || (OP_GAP == 0)) begin
                    if (pc_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = StFetch;
                    end
                end else begin
                    gap_d   = GapW'(OP_GAP);
                    state_d = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q - GapW'(1);
                if (gap_q == GapW'(1)) begin
                    if (pc_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // Registered status outputs are decoded from the state being entered
    always_comb begin
        ce_d   = (state_d == StIssue);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= 4'd0;
            last_q  <= 4'd0;
            gap_q   <= '0;
            cmd_q   <= 18'd0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load    = cmd_q[17];
    assign cin     = cmd_q[16];
    assign opcode  = cmd_q[15:8];
    assign data_in = cmd_q[7:0];
    assign ce      = ce_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios plus randomized programs,
// checked cycle by cycle against an expected timeline built from the program.
module tb_alu_cmd_sequencer;

    localparam int unsigned GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'd0;
    logic [17:0] prog_data = 18'd0;
    logic [3:0]  prog_last = 4'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  data_in;
    logic [7:0]  opcode;
    logic        cin;
    logic        load;
    logic        ce;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: program contents and command fields last presented
    logic [17:0] mem_m [16];
    logic [17:0] fld_m;

    // Expected timeline of one run, index = cycles after the start cycle
    logic [2:0]  sig_t [0:80];   // {done, busy, ce}
    logic [17:0] fld_t [0:80];   // {load, cin, opcode, data_in}

    alu_cmd_sequencer #(.OP_GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_last (prog_last),
        .start     (start),
        .abort     (abort),
        .data_in   (data_in),
        .opcode    (opcode),
        .cin       (cin),
        .load      (load),
        .ce        (ce),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge while idle
    task automatic write_mem(input int addr, input logic [17:0] data);
        prog_we   = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
        mem_m[addr] = data;
    endtask

    // One run: abort_at/stray_k = 0 means none; values past the run are ignored.
    // The stray cycle pulses start and writes mem[3] while busy; both must be ignored.
    task automatic run_prog(input int last, input int abort_at, input int stray_k,
                            input bit both);
        int t;
        int n;
        logic [17:0] f;
        f = fld_m;
        t = 1;
        for (int i = 0; i <= last; i++) begin
            sig_t[t] = 3'b010;
            fld_t[t] = f;
            f = mem_m[i];
            sig_t[t+1] = 3'b011;
            fld_t[t+1] = f;
            if (!f[17]) begin
                for (int g = 0; g < int'(GAP); g++) begin
                    sig_t[t+2+g] = 3'b010;
                    fld_t[t+2+g] = f;
                end
                t += 2 + int'(GAP);
            end else begin
                t += 2;
            end
        end
        sig_t[t]   = 3'b110;
        fld_t[t]   = f;
        sig_t[t+1] = 3'b000;
        fld_t[t+1] = f;
        n = t + 1;
        if (abort_at >= 1 && abort_at < n) begin
            sig_t[abort_at+1] = 3'b000;
            fld_t[abort_at+1] = fld_t[abort_at];
            n = abort_at + 1;
        end

        // Cycle 0: start request, optionally with abort (start must win)
        prog_last = 4'(last);
        start = 1'b1;
        abort = both;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check_eq($sformatf("ctl[k=%0d]", k), {29'd0, done, busy, ce}, {29'd0, sig_t[k]});
            check_eq($sformatf("fld[k=%0d]", k), {14'd0, load, cin, opcode, data_in},
                     {14'd0, fld_t[k]});
            abort     = (k == abort_at) && (k < n);
            start     = (k == stray_k) && (k < n);
            prog_we   = (k == stray_k) && (k < n);
            prog_addr = 4'd3;
            prog_data = 18'($urandom);
            @(negedge clk);
            abort   = 1'b0;
            start   = 1'b0;
            prog_we = 1'b0;
        end
        fld_m = fld_t[n];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = 18'd0;
        fld_m = 18'd0;
        repeat (2) @(negedge clk);
        check_eq("reset_ctl", {29'd0, done, busy, ce}, 32'd0);
        check_eq("reset_fld", {14'd0, load, cin, opcode, data_in}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Load r1 then ALU op on r1: ce at cycles 2 and 4, done at 7
        write_mem(0, 18'h2_0012);
        write_mem(1, 18'h0_1300);
        run_prog(1, 0, 0, 1'b0);

        // Single load instruction
        run_prog(0, 0, 0, 1'b0);

        // Sixteen loads, no wrap past 15
        for (int i = 0; i < 16; i++) write_mem(i, {2'b10, 8'(i + 8'h40), 8'(i * 13 + 5)});
        run_prog(15, 0, 0, 1'b0);

        // Abort during the gap of instruction 0, then rerun from pc=0
        write_mem(0, 18'h1_2277);
        run_prog(1, 3, 0, 1'b0);
        run_prog(1, 0, 0, 1'b0);

        // Write to mem[3] and start while busy, then rerun reading mem[3]
        run_prog(4, 0, 5, 1'b0);
        run_prog(4, 0, 0, 1'b1);

        // Asynchronous reset during ISSUE
        write_mem(0, 18'h2_0055);
        prog_last = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_issue_ce", {31'd0, ce}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_ctl", {29'd0, done, busy, ce}, 32'd0);
        check_eq("rst_async_fld", {14'd0, load, cin, opcode, data_in}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fld_m = 18'd0;
        @(negedge clk);
        check_eq("rst_after_ctl", {29'd0, done, busy, ce}, 32'd0);

        // Randomized programs, aborts, stray writes/starts
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 16; i++) write_mem(i, 18'($urandom));
            run_prog($urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 66) : 0,
                     ($urandom_range(0, 1) == 0) ? $urandom_range(1, 66) : 0,
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
